axi_skid_slice: RTL and testbench
=================================

AXI_SKID_SLICE -- requirements
Module: axi_skid_slice

Interface
REQ-001 SHALL have parameter REG_AW, default 1, meaning 1 = AW channel registered, 0 = combinational pass-through.
REQ-002 SHALL have parameter REG_W, default 1, with the same meaning for the W channel.
REQ-003 SHALL have parameter REG_B, default 1, with the same meaning for the B channel.
REQ-004 SHALL have parameter REG_AR, default 1, with the same meaning for the AR channel.
REQ-005 SHALL have parameter REG_R, default 1, with the same meaning for the R channel.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-007 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port s_axi, if_axi_light.slave, widths `AXI_ADDR_WIDTH/`AXI_DATA_WIDTH: upstream side, fed by the master or core.
REQ-009 SHALL have port m_axi, if_axi_light.master, same widths: downstream side, feeding the axi_offset stage.

Function
REQ-010 Each registered channel SHALL be a two-entry skid buffer (main + skid register) carrying its payload:
- AW: awaddr, awprot
- W: wdata, wstrb
- B: bresp
- AR: araddr, arprot
- R: rdata, rresp
REQ-011 Forward latency SHALL be exactly 1 cycle: a beat accepted on the input at edge N is presented valid on the output after edge N.
REQ-012 Throughput SHALL be one beat per cycle per channel while the output ready is held high.
REQ-013 Input ready SHALL be a registered signal equal to NOT skid_valid, so no combinational path runs from output ready to input ready.
REQ-014 A beat SHALL transfer on the input when in_valid AND in_ready; load rules:
- main empty, or main draining this cycle: the beat loads into main.
- otherwise: the beat loads into skid, and in_ready drops on the next cycle.
REQ-015 When main drains (out_valid AND out_ready) and skid is full, skid SHALL move into main in the same edge, skid is cleared, and in_ready returns high.
REQ-016 Full boundary: with main and skid both full, in_ready SHALL be 0 and no input beat is accepted; a simultaneous drain frees exactly one entry.
REQ-017 Empty boundary: with both entries empty, out_valid SHALL be 0, and the output payload holds its last value (no X propagation required).
REQ-018 Simultaneous input accept and output drain on a buffer holding one beat SHALL keep occupancy at one entry, with the new beat in main.
REQ-019 Once asserted, out_valid SHALL not drop, and the output payload SHALL not change, until out_ready is sampled high (AXI stability rule).
REQ-020 Beat order SHALL be preserved per channel; channels SHALL be mutually independent, with no AW/W coupling inside the slice.
REQ-021 A channel whose REG_* parameter is 0 SHALL connect valid, ready and payload straight through, with no added state.
REQ-022 Addresses, data and strobes SHALL pass bit-exact; the block performs no arithmetic on any field.

Reset
REQ-023 While resetn is low, all main_valid and skid_valid bits SHALL be 0, so every m_axi valid and every s_axi valid is 0.
REQ-024 While resetn is low, all registered input readies SHALL be 0; they rise to 1 on the first clk edge after resetn deasserts.
REQ-025 Payload registers SHALL not require reset; they reset to 0 only if that costs nothing.
REQ-026 Reset asserted mid-operation SHALL discard all buffered beats immediately and asynchronously, without waiting for a clock edge.

Structure
REQ-027 Payload width localparams (AW_W, W_W, B_W, AR_W, R_W) SHALL live in shared package axi_light_pkg, derived from `AXI_ADDR_WIDTH and `AXI_DATA_WIDTH.
REQ-028 A single sub-module axi_skid_buf, parameterised by WIDTH, SHALL implement REQ-010 to REQ-019 and be instantiated once per registered channel via generate.
REQ-029 The top level SHALL only pack/unpack payloads and select between skid buffer and pass-through per channel.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Streaming: AW beats 0x100, 0x104, 0x108 on consecutive cycles, m_awready=1 -> same addresses appear on m_axi one cycle later, back-to-back, s_awready constant 1.
- Backpressure: m_wready=0, push W 0xAAAA0001, 0xAAAA0002, then offer 0xAAAA0003 -> s_wready=0 after the second beat; raising m_wready yields 0x..01, 0x..02, 0x..03 in order, nothing lost or duplicated.
- Stability: m_arready=0 with araddr 0x2000 held at m_axi for 5 cycles -> m_arvalid and m_araddr unchanged throughout.
- Simultaneous accept/drain: one R beat rdata=0x11 buffered, then rdata=0x22 offered while m_rready... s_rready=1 -> 0x11 delivered, 0x22 in main, occupancy stays 1.
- Reset mid-operation: both AW entries full, resetn pulsed low between edges -> m_awvalid=0 immediately; s_awready=0 until the first edge after release, then 1; stale addresses never appear.
- Pass-through: REG_B=0 -> bvalid/bresp=2'b10 visible on s_axi in the same cycle as on m_axi.

Source files
------------

// File: rtl/axi_light_pkg.sv
// ============================================================================
// Module      : axi_light_pkg
// Description : Shared widths for the AXI-light register slice. Payload widths
//               are derived from the global address/data width macros.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package axi_light_pkg;

    localparam int ADDR_W = `AXI_ADDR_WIDTH;
    localparam int DATA_W = `AXI_DATA_WIDTH;
    localparam int STRB_W = DATA_W / 8;
    localparam int PROT_W = 3;
    localparam int RESP_W = 2;

    // Packed payload widths, one per channel
    localparam int AW_W = ADDR_W + PROT_W;   // {awaddr, awprot}
    localparam int W_W  = DATA_W + STRB_W;   // {wdata, wstrb}
    localparam int B_W  = RESP_W;            // {bresp}
    localparam int AR_W = ADDR_W + PROT_W;   // {araddr, arprot}
    localparam int R_W  = DATA_W + RESP_W;   // {rdata, rresp}

endpackage

`default_nettype wire

// File: rtl/if_axi_light.sv
// ============================================================================
// Module      : if_axi_light
// Description : Lightweight AXI bundle (AW/W/B/AR/R, no IDs or bursts).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

interface if_axi_light;

    logic                           awvalid;
    logic                           awready;
    logic [`AXI_ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                     awprot;

    logic                           wvalid;
    logic                           wready;
    logic [`AXI_DATA_WIDTH-1:0]     wdata;
    logic [`AXI_DATA_WIDTH/8-1:0]   wstrb;

    logic                           bvalid;
    logic                           bready;
    logic [1:0]                     bresp;

    logic                           arvalid;
    logic                           arready;
    logic [`AXI_ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                     arprot;

    logic                           rvalid;
    logic                           rready;
    logic [`AXI_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                     rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb,    input wready,
        input  bvalid, bresp,           output bready,
        output arvalid, araddr, arprot, input arready,
        input  rvalid, rdata, rresp,    output rready
    );

    modport slave (
        input  awvalid, awaddr, awprot, output awready,
        input  wvalid, wdata, wstrb,    output wready,
        output bvalid, bresp,           input bready,
        input  arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp,    input rready
    );

endinterface

`default_nettype wire

// File: rtl/axi_skid_buf.sv
// ============================================================================
// Module      : axi_skid_buf
// Description : Two-entry skid buffer (main + skid) for one valid/ready
//               channel. One-cycle forward latency, full throughput, and an
//               input ready that is purely registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_valid_nxt;
    logic             w_skid_valid_nxt;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    // Next-state decode. While skid is full r_in_ready is low, so an input
    // beat can never coincide with a skid-to-main move.
    always_comb begin
        w_in_fire        = i_in_valid & r_in_ready;
        w_out_fire       = r_main_valid & i_out_ready;
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;

        if (w_out_fire && r_skid_valid) begin
            w_load_main_skid = 1'b1;
            w_main_valid_nxt = 1'b1;
            w_skid_valid_nxt = 1'b0;
        end else if (w_in_fire && (!r_main_valid || w_out_fire)) begin
            w_load_main_in   = 1'b1;
            w_main_valid_nxt = 1'b1;
        end else if (w_in_fire) begin
            w_load_skid      = 1'b1;
            w_skid_valid_nxt = 1'b1;
        end else if (w_out_fire) begin
            w_main_valid_nxt = 1'b0;
        end
    end

    // Occupancy flags and registered input ready; cleared asynchronously
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    // Payload storage needs no reset: it is only observed while valid is set
    always_ff @(posedge clk) begin
        if (w_load_main_in) begin
            r_main_data <= i_in_data;
        end else if (w_load_main_skid) begin
            r_main_data <= r_skid_data;
        end
        if (w_load_skid) begin
            r_skid_data <= i_in_data;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_main_valid;
    assign o_out_data  = r_main_data;

endmodule

`default_nettype wire

// File: rtl/axi_skid_slice.sv
// ============================================================================
// Module      : axi_skid_slice
// Description : AXI-light register slice. Each of the five channels is either
//               a skid buffer or a wire, chosen by its REG_* parameter. The
//               channels are fully independent of each other.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_skid_slice
    import axi_light_pkg::*;
#(
    parameter int REG_AW = 1,
    parameter int REG_W  = 1,
    parameter int REG_B  = 1,
    parameter int REG_AR = 1,
    parameter int REG_R  = 1
) (
    input  logic           clk,
    input  logic           resetn,
    if_axi_light.slave     s_axi,
    if_axi_light.master    m_axi
);

    logic [AW_W-1:0] w_aw_in, w_aw_out;
    logic [W_W-1:0]  w_w_in,  w_w_out;
    logic [B_W-1:0]  w_b_in,  w_b_out;
    logic [AR_W-1:0] w_ar_in, w_ar_out;
    logic [R_W-1:0]  w_r_in,  w_r_out;

    // Payload packing: requests flow s->m, responses flow m->s
    assign w_aw_in = {s_axi.awaddr, s_axi.awprot};
    assign w_w_in  = {s_axi.wdata,  s_axi.wstrb};
    assign w_b_in  = m_axi.bresp;
    assign w_ar_in = {s_axi.araddr, s_axi.arprot};
    assign w_r_in  = {m_axi.rdata,  m_axi.rresp};

    assign {m_axi.awaddr, m_axi.awprot} = w_aw_out;
    assign {m_axi.wdata,  m_axi.wstrb}  = w_w_out;
    assign s_axi.bresp                  = w_b_out;
    assign {m_axi.araddr, m_axi.arprot} = w_ar_out;
    assign {s_axi.rdata,  s_axi.rresp}  = w_r_out;

    generate
        if (REG_AW != 0) begin : g_aw_reg
            axi_skid_buf #(.WIDTH(AW_W)) u_buf (
                .clk(clk), .resetn(resetn),
                .i_in_valid(s_axi.awvalid), .o_in_ready(s_axi.awready), .i_in_data(w_aw_in),
                .o_out_valid(m_axi.awvalid), .i_out_ready(m_axi.awready), .o_out_data(w_aw_out)
            );
        end else begin : g_aw_pass
            assign m_axi.awvalid = s_axi.awvalid;
            assign s_axi.awready = m_axi.awready;
            assign w_aw_out      = w_aw_in;
        end

        if (REG_W != 0) begin : g_w_reg
            axi_skid_buf #(.WIDTH(W_W)) u_buf (
                .clk(clk), .resetn(resetn),
                .i_in_valid(s_axi.wvalid), .o_in_ready(s_axi.wready), .i_in_data(w_w_in),
                .o_out_valid(m_axi.wvalid), .i_out_ready(m_axi.wready), .o_out_data(w_w_out)
            );
        end else begin : g_w_pass
            assign m_axi.wvalid = s_axi.wvalid;
            assign s_axi.wready = m_axi.wready;
            assign w_w_out      = w_w_in;
        end

        if (REG_B != 0) begin : g_b_reg
            axi_skid_buf #(.WIDTH(B_W)) u_buf (
                .clk(clk), .resetn(resetn),
                .i_in_valid(m_axi.bvalid), .o_in_ready(m_axi.bready), .i_in_data(w_b_in),
                .o_out_valid(s_axi.bvalid), .i_out_ready(s_axi.bready), .o_out_data(w_b_out)
            );
        end else begin : g_b_pass
            assign s_axi.bvalid = m_axi.bvalid;
            assign m_axi.bready = s_axi.bready;
            assign w_b_out      = w_b_in;
        end

        if (REG_AR != 0) begin : g_ar_reg
            axi_skid_buf #(.WIDTH(AR_W)) u_buf (
                .clk(clk), .resetn(resetn),
                .i_in_valid(s_axi.arvalid), .o_in_ready(s_axi.arready), .i_in_data(w_ar_in),
                .o_out_valid(m_axi.arvalid), .i_out_ready(m_axi.arready), .o_out_data(w_ar_out)
            );
        end else begin : g_ar_pass
            assign m_axi.arvalid = s_axi.arvalid;
            assign s_axi.arready = m_axi.arready;
            assign w_ar_out      = w_ar_in;
        end

        if (REG_R != 0) begin : g_r_reg
            axi_skid_buf #(.WIDTH(R_W)) u_buf (
                .clk(clk), .resetn(resetn),
                .i_in_valid(m_axi.rvalid), .o_in_ready(m_axi.rready), .i_in_data(w_r_in),
                .o_out_valid(s_axi.rvalid), .i_out_ready(s_axi.rready), .o_out_data(w_r_out)
            );
        end else begin : g_r_pass
            assign s_axi.rvalid = m_axi.rvalid;
            assign m_axi.rready = s_axi.rready;
            assign w_r_out      = w_r_in;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_axi_skid_slice.sv
// ============================================================================
// Module      : tb_axi_skid_slice
// Description : Self-checking bench for axi_skid_slice. Directed scenarios plus
//               a randomized AR/R run checked against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_skid_slice;
    import axi_light_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    if_axi_light s_if ();
    if_axi_light m_if ();
    if_axi_light s2_if ();
    if_axi_light m2_if ();

    axi_skid_slice u_dut (
        .clk(clk), .resetn(resetn), .s_axi(s_if), .m_axi(m_if)
    );

    axi_skid_slice #(.REG_B(0)) u_dut_pt (
        .clk(clk), .resetn(resetn), .s_axi(s2_if), .m_axi(m2_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        s_if.awvalid = 0; s_if.awaddr = '0; s_if.awprot = '0;
        s_if.wvalid  = 0; s_if.wdata  = '0; s_if.wstrb  = '0;
        s_if.bready  = 0;
        s_if.arvalid = 0; s_if.araddr = '0; s_if.arprot = '0;
        s_if.rready  = 0;
        m_if.awready = 0; m_if.wready = 0; m_if.arready = 0;
        m_if.bvalid  = 0; m_if.bresp  = '0;
        m_if.rvalid  = 0; m_if.rdata  = '0; m_if.rresp = '0;
        s2_if.awvalid = 0; s2_if.awaddr = '0; s2_if.awprot = '0;
        s2_if.wvalid  = 0; s2_if.wdata  = '0; s2_if.wstrb  = '0;
        s2_if.bready  = 0;
        s2_if.arvalid = 0; s2_if.araddr = '0; s2_if.arprot = '0;
        s2_if.rready  = 0;
        m2_if.awready = 0; m2_if.wready = 0; m2_if.arready = 0;
        m2_if.bvalid  = 0; m2_if.bresp  = '0;
        m2_if.rvalid  = 0; m2_if.rdata  = '0; m2_if.rresp = '0;
    endtask

    task automatic test_reset();
        logic [4:0] vld, rdy;
        idle_all();
        resetn = 1'b0;
        #1;
        vld = {m_if.awvalid, m_if.wvalid, s_if.bvalid, m_if.arvalid, s_if.rvalid};
        rdy = {s_if.awready, s_if.wready, m_if.bready, s_if.arready, m_if.rready};
        n_checks++;
        if (vld !== 5'b0) $display("FAIL reset_valids: got %b expected %b", vld, 5'b0);
        else n_pass++;
        n_checks++;
        if (rdy !== 5'b0) $display("FAIL reset_readies: got %b expected %b", rdy, 5'b0);
        else n_pass++;
        tick();
        tick();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        rdy = {s_if.awready, s_if.wready, m_if.bready, s_if.arready, m_if.rready};
        n_checks++;
        if (rdy !== 5'b0) $display("FAIL release_before_edge_readies: got %b expected %b", rdy, 5'b0);
        else n_pass++;
        tick();
        rdy = {s_if.awready, s_if.wready, m_if.bready, s_if.arready, m_if.rready};
        n_checks++;
        if (rdy !== 5'b11111) $display("FAIL first_edge_readies: got %b expected %b", rdy, 5'b11111);
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic [ADDR_W-1:0] addrs [3];
        addrs[0] = 'h100; addrs[1] = 'h104; addrs[2] = 'h108;
        m_if.awready = 1;
        s_if.awvalid = 1;
        for (int i = 0; i < 3; i++) begin
            s_if.awaddr = addrs[i];
            s_if.awprot = 3'(i);
            tick();
            n_checks++;
            if (m_if.awvalid !== 1'b1 || m_if.awaddr !== addrs[i] || m_if.awprot !== 3'(i))
                $display("FAIL stream_beat%0d: got v=%b a=%h p=%0d expected v=1 a=%h p=%0d",
                         i, m_if.awvalid, m_if.awaddr, m_if.awprot, addrs[i], i);
            else n_pass++;
            n_checks++;
            if (s_if.awready !== 1'b1) $display("FAIL stream_ready%0d: got %b expected 1", i, s_if.awready);
            else n_pass++;
        end
        s_if.awvalid = 0;
        tick();
        n_checks++;
        if (m_if.awvalid !== 1'b0) $display("FAIL stream_empty: got %b expected 0", m_if.awvalid);
        else n_pass++;
        m_if.awready = 0;
    endtask

    task automatic test_backpressure();
        m_if.wready = 0;
        s_if.wvalid = 1; s_if.wstrb = '1;
        s_if.wdata  = 'hAAAA0001;
        tick();
        n_checks++;
        if (s_if.wready !== 1'b1 || m_if.wvalid !== 1'b1 || m_if.wdata !== 'hAAAA0001)
            $display("FAIL bp_first: got rdy=%b v=%b d=%h expected rdy=1 v=1 d=aaaa0001",
                     s_if.wready, m_if.wvalid, m_if.wdata);
        else n_pass++;
        s_if.wdata = 'hAAAA0002;
        tick();
        n_checks++;
        if (s_if.wready !== 1'b0 || m_if.wdata !== 'hAAAA0001)
            $display("FAIL bp_full: got rdy=%b d=%h expected rdy=0 d=aaaa0001", s_if.wready, m_if.wdata);
        else n_pass++;
        s_if.wdata = 'hAAAA0003;
        tick();
        n_checks++;
        if (s_if.wready !== 1'b0 || m_if.wdata !== 'hAAAA0001 || m_if.wvalid !== 1'b1)
            $display("FAIL bp_hold: got rdy=%b v=%b d=%h expected rdy=0 v=1 d=aaaa0001",
                     s_if.wready, m_if.wvalid, m_if.wdata);
        else n_pass++;
        m_if.wready = 1;
        tick();
        n_checks++;
        if (m_if.wdata !== 'hAAAA0002 || s_if.wready !== 1'b1 || m_if.wvalid !== 1'b1)
            $display("FAIL bp_second: got rdy=%b v=%b d=%h expected rdy=1 v=1 d=aaaa0002",
                     s_if.wready, m_if.wvalid, m_if.wdata);
        else n_pass++;
        tick();
        n_checks++;
        if (m_if.wdata !== 'hAAAA0003 || m_if.wvalid !== 1'b1)
            $display("FAIL bp_third: got v=%b d=%h expected v=1 d=aaaa0003", m_if.wvalid, m_if.wdata);
        else n_pass++;
        s_if.wvalid = 0;
        tick();
        n_checks++;
        if (m_if.wvalid !== 1'b0) $display("FAIL bp_drained: got %b expected 0", m_if.wvalid);
        else n_pass++;
        m_if.wready = 0;
    endtask

    task automatic test_stability();
        m_if.arready = 0;
        s_if.arvalid = 1; s_if.araddr = 'h2000; s_if.arprot = 3'd0;
        tick();
        s_if.arvalid = 0;
        s_if.araddr  = 'h5555;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (m_if.arvalid !== 1'b1 || m_if.araddr !== 'h2000)
                $display("FAIL stable_cyc%0d: got v=%b a=%h expected v=1 a=2000", k, m_if.arvalid, m_if.araddr);
            else n_pass++;
            tick();
        end
        m_if.arready = 1;
        tick();
        n_checks++;
        if (m_if.arvalid !== 1'b0) $display("FAIL stable_drain: got %b expected 0", m_if.arvalid);
        else n_pass++;
        m_if.arready = 0;
    endtask

    task automatic test_simul_accept_drain();
        s_if.rready = 0;
        m_if.rvalid = 1; m_if.rdata = 'h11; m_if.rresp = 2'b00;
        tick();
        n_checks++;
        if (s_if.rvalid !== 1'b1 || s_if.rdata !== 'h11)
            $display("FAIL simul_first: got v=%b d=%h expected v=1 d=11", s_if.rvalid, s_if.rdata);
        else n_pass++;
        m_if.rdata = 'h22; m_if.rresp = 2'b01;
        s_if.rready = 1;
        #1;
        n_checks++;
        if (s_if.rdata !== 'h11) $display("FAIL simul_deliver: got %h expected 11", s_if.rdata);
        else n_pass++;
        tick();
        n_checks++;
        if (s_if.rvalid !== 1'b1 || s_if.rdata !== 'h22 || s_if.rresp !== 2'b01 || m_if.rready !== 1'b1)
            $display("FAIL simul_occupancy: got v=%b d=%h r=%b rdy=%b expected v=1 d=22 r=01 rdy=1",
                     s_if.rvalid, s_if.rdata, s_if.rresp, m_if.rready);
        else n_pass++;
        m_if.rvalid = 0;
        tick();
        n_checks++;
        if (s_if.rvalid !== 1'b0) $display("FAIL simul_drained: got %b expected 0", s_if.rvalid);
        else n_pass++;
        s_if.rready = 0;
    endtask

    task automatic test_reset_mid();
        m_if.awready = 0;
        s_if.awvalid = 1; s_if.awaddr = 'hA0;
        tick();
        s_if.awaddr = 'hA4;
        tick();
        n_checks++;
        if (s_if.awready !== 1'b0 || m_if.awvalid !== 1'b1)
            $display("FAIL rstmid_full: got rdy=%b v=%b expected rdy=0 v=1", s_if.awready, m_if.awvalid);
        else n_pass++;
        s_if.awvalid = 0;
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (m_if.awvalid !== 1'b0 || s_if.awready !== 1'b0)
            $display("FAIL rstmid_async: got v=%b rdy=%b expected v=0 rdy=0", m_if.awvalid, s_if.awready);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        m_if.awready = 1;
        #1;
        n_checks++;
        if (s_if.awready !== 1'b0) $display("FAIL rstmid_release: got %b expected 0", s_if.awready);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (s_if.awready !== 1'b1 || m_if.awvalid !== 1'b0)
                $display("FAIL rstmid_after%0d: got rdy=%b v=%b expected rdy=1 v=0", k, s_if.awready, m_if.awvalid);
            else n_pass++;
        end
        m_if.awready = 0;
    endtask

    task automatic test_passthrough();
        m2_if.bvalid = 1; m2_if.bresp = 2'b10; s2_if.bready = 1;
        m_if.bvalid  = 1; m_if.bresp  = 2'b10; s_if.bready  = 0;
        #1;
        n_checks++;
        if (s2_if.bvalid !== 1'b1 || s2_if.bresp !== 2'b10 || m2_if.bready !== 1'b1)
            $display("FAIL pt_same_cycle: got v=%b r=%b rdy=%b expected v=1 r=10 rdy=1",
                     s2_if.bvalid, s2_if.bresp, m2_if.bready);
        else n_pass++;
        n_checks++;
        if (s_if.bvalid !== 1'b0) $display("FAIL b_reg_not_comb: got %b expected 0", s_if.bvalid);
        else n_pass++;
        tick();
        n_checks++;
        if (s_if.bvalid !== 1'b1 || s_if.bresp !== 2'b10)
            $display("FAIL b_reg_latency: got v=%b r=%b expected v=1 r=10", s_if.bvalid, s_if.bresp);
        else n_pass++;
        m2_if.bvalid = 0;
        m_if.bvalid  = 0;
        s_if.bready  = 1;
        #1;
        n_checks++;
        if (s2_if.bvalid !== 1'b0) $display("FAIL pt_drop: got %b expected 0", s2_if.bvalid);
        else n_pass++;
        tick();
        n_checks++;
        if (s_if.bvalid !== 1'b0) $display("FAIL b_reg_drained: got %b expected 0", s_if.bvalid);
        else n_pass++;
        s_if.bready = 0; s2_if.bready = 0;
    endtask

    // Model: each channel is a FIFO of depth two; the output shows the head,
    // input ready means fewer than two beats are held.
    task automatic test_random_ar_r();
        logic [AR_W-1:0] ar_q [$];
        logic [R_W-1:0]  r_q  [$];
        logic [AR_W-1:0] ar_d;
        logic [R_W-1:0]  r_d;
        logic ar_v, ar_rdy, r_v, r_rdy, ar_in, ar_out, r_in, r_out;
        for (int cyc = 0; cyc < 300; cyc++) begin
            ar_v   = ($urandom_range(0, 3) != 0);
            ar_rdy = ($urandom_range(0, 2) != 0);
            r_v    = ($urandom_range(0, 2) != 0);
            r_rdy  = ($urandom_range(0, 3) != 0);
            ar_d   = AR_W'({$urandom(), $urandom()});
            r_d    = R_W'({$urandom(), $urandom()});
            if (cyc > 250) begin
                ar_v = 0; r_v = 0; ar_rdy = 1; r_rdy = 1;
            end
            s_if.arvalid = ar_v; {s_if.araddr, s_if.arprot} = ar_d; m_if.arready = ar_rdy;
            m_if.rvalid  = r_v;  {m_if.rdata, m_if.rresp}   = r_d;  s_if.rready  = r_rdy;
            ar_in  = ar_v && (ar_q.size() < 2);
            ar_out = (ar_q.size() > 0) && ar_rdy;
            r_in   = r_v && (r_q.size() < 2);
            r_out  = (r_q.size() > 0) && r_rdy;
            tick();
            if (ar_out) void'(ar_q.pop_front());
            if (ar_in)  ar_q.push_back(ar_d);
            if (r_out)  void'(r_q.pop_front());
            if (r_in)   r_q.push_back(r_d);

            n_checks++;
            if (m_if.arvalid !== (ar_q.size() > 0) || s_if.arready !== (ar_q.size() < 2))
                $display("FAIL rnd_ar_flags cyc%0d: got v=%b rdy=%b expected v=%b rdy=%b", cyc,
                         m_if.arvalid, s_if.arready, ar_q.size() > 0, ar_q.size() < 2);
            else n_pass++;
            if (ar_q.size() > 0) begin
                n_checks++;
                if ({m_if.araddr, m_if.arprot} !== ar_q[0])
                    $display("FAIL rnd_ar_data cyc%0d: got %h expected %h", cyc,
                             {m_if.araddr, m_if.arprot}, ar_q[0]);
                else n_pass++;
            end
            n_checks++;
            if (s_if.rvalid !== (r_q.size() > 0) || m_if.rready !== (r_q.size() < 2))
                $display("FAIL rnd_r_flags cyc%0d: got v=%b rdy=%b expected v=%b rdy=%b", cyc,
                         s_if.rvalid, m_if.rready, r_q.size() > 0, r_q.size() < 2);
            else n_pass++;
            if (r_q.size() > 0) begin
                n_checks++;
                if ({s_if.rdata, s_if.rresp} !== r_q[0])
                    $display("FAIL rnd_r_data cyc%0d: got %h expected %h", cyc,
                             {s_if.rdata, s_if.rresp}, r_q[0]);
                else n_pass++;
            end
        end
        idle_all();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_stability();
        test_simul_accept_drain();
        test_reset_mid();
        test_passthrough();
        test_random_ar_r();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
